// File: rtl/fmpu_pkg.sv
// rtl/fmpu_pkg.sv - FP16 field widths, requester state enum and operand unpack helper
package fmpu_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int MANT_W  = 11;
    localparam int PMANT_W = 22;
    localparam int PEXP_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } req_state_e;

    typedef struct packed {
        logic [SIGN_W-1:0] sgn;
        logic [EXP_W-1:0]  ex;
        logic [MANT_W-1:0] mant;
    } fp16_fields_t;

    // Raw field split; the hidden bit is the only derived value, specials pass through untouched.
    function automatic fp16_fields_t fp16_unpack(input logic [15:0] word);
        fp16_fields_t f;
        f.sgn  = word[15];
        f.ex   = word[14:10];
        f.mant = {(word[14:10] != 5'd0), word[FRAC_W-1:0]};
        return f;
    endfunction

endpackage

// File: rtl/fmpu_rr_arb.sv
// rtl/fmpu_rr_arb.sv - round-robin arbiter, one-hot grant searched from last_grant+1
module fmpu_rr_arb #(
    parameter int NREQ  = 2,
    parameter int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  eligible,
    input  logic             advance,
    output logic [NREQ-1:0]  grant,
    output logic [TAG_W-1:0] last_grant
);

    logic [TAG_W-1:0] win;
    logic             found;

    // Nearest eligible requester after last_grant wins; indices stay constant after unrolling.
    always_comb begin
        grant = '0;
        win   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (int'(last_grant) == j) && eligible[(j + k) % NREQ]) begin
                    grant[(j + k) % NREQ] = 1'b1;
                    win                   = TAG_W'((j + k) % NREQ);
                    found                 = 1'b1;
                end
            end
        end
    end

    // Pointer moves only when a grant is actually taken; reset gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= TAG_W'(NREQ - 1);
        end else if (advance) begin
            last_grant <= win;
        end
    end

endmodule

// File: rtl/fmpu_sched.sv
// rtl/fmpu_sched.sv - shares one fmpu multiplier among NREQ requesters with tagged in-order returns
module fmpu_sched
    import fmpu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 1,
    parameter int TAG_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk_alu,
    input  logic                    rst_alu_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [16*NREQ-1:0]      req_a,
    input  logic [16*NREQ-1:0]      req_b,
    output logic [MANT_W-1:0]       mul_a_mant,
    output logic [MANT_W-1:0]       mul_b_mant,
    output logic [EXP_W-1:0]        mul_a_exp,
    output logic [EXP_W-1:0]        mul_b_exp,
    output logic                    mul_a_sign,
    output logic                    mul_b_sign,
    input  logic [PMANT_W-1:0]      mul_res_mant,
    input  logic [PEXP_W-1:0]       mul_res_exp,
    input  logic                    mul_res_sign,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [PMANT_W*NREQ-1:0] rsp_mant,
    output logic [PEXP_W*NREQ-1:0]  rsp_exp,
    output logic [NREQ-1:0]         rsp_sign,
    output logic                    busy
);

    req_state_e       state     [NREQ];
    req_state_e       state_nxt [NREQ];
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [TAG_W-1:0] last_grant;
    logic [15:0]      sel_a, sel_b;
    fp16_fields_t     fa, fb;
    logic [MUL_LAT:0] pipe_valid;
    logic [TAG_W-1:0] tag_q [MUL_LAT];
    logic             exit_valid;
    logic [TAG_W-1:0] exit_tag;

    fmpu_rr_arb #(.NREQ(NREQ), .TAG_W(TAG_W)) u_arb (
        .clk        (clk_alu),
        .rst_n      (rst_alu_n),
        .eligible   (eligible),
        .advance    (|grant),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign req_ready  = grant;
    assign exit_valid = pipe_valid[MUL_LAT];
    assign exit_tag   = tag_q[MUL_LAT-1];

    // One-hot operand select of the granted requester, then FP16 field split.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*16 +: 16];
                sel_b = req_b[i*16 +: 16];
            end
        end
        fa = fp16_unpack(sel_a);
        fb = fp16_unpack(sel_b);
    end

    // Operand registers load only on a grant so the multiplier inputs stay quiet otherwise.
    always_ff @(posedge clk_alu or negedge rst_alu_n) begin
        if (!rst_alu_n) begin
            mul_a_mant <= '0;
            mul_b_mant <= '0;
            mul_a_exp  <= '0;
            mul_b_exp  <= '0;
            mul_a_sign <= 1'b0;
            mul_b_sign <= 1'b0;
        end else if (|grant) begin
            mul_a_mant <= fa.mant;
            mul_b_mant <= fb.mant;
            mul_a_exp  <= fa.ex;
            mul_b_exp  <= fb.ex;
            mul_a_sign <= fa.sgn;
            mul_b_sign <= fb.sgn;
        end
    end

    // Tag pipeline: stage 0 carries only valid because the arbiter pointer already holds
    // the winner during the cycle after the grant; tags are registered from stage 1 on.
    always_ff @(posedge clk_alu or negedge rst_alu_n) begin
        if (!rst_alu_n) begin
            pipe_valid <= '0;
            for (int s = 0; s < MUL_LAT; s++) tag_q[s] <= '0;
        end else begin
            pipe_valid[0] <= |grant;
            for (int s = 1; s <= MUL_LAT; s++) pipe_valid[s] <= pipe_valid[s-1];
            tag_q[0] <= last_grant;
            for (int s = 1; s < MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Result capture into the slot of the exiting tag; data holds until the next capture.
    always_ff @(posedge clk_alu or negedge rst_alu_n) begin
        if (!rst_alu_n) begin
            rsp_mant <= '0;
            rsp_exp  <= '0;
            rsp_sign <= '0;
        end else if (exit_valid) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exit_tag == TAG_W'(i)) begin
                    rsp_mant[i*PMANT_W +: PMANT_W] <= mul_res_mant;
                    rsp_exp[i*PEXP_W +: PEXP_W]    <= mul_res_exp;
                    rsp_sign[i]                    <= mul_res_sign;
                end
            end
        end
    end

    // Per-requester state register.
    always_ff @(posedge clk_alu or negedge rst_alu_n) begin
        if (!rst_alu_n) begin
            for (int i = 0; i < NREQ; i++) state[i] <= IDLE;
        end else begin
            for (int i = 0; i < NREQ; i++) state[i] <= state_nxt[i];
        end
    end

    // Per-requester next state, eligibility, response valid and aggregate busy.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                IDLE:    if (grant[i]) state_nxt[i] = BUSY;
                BUSY:    if (exit_valid && (exit_tag == TAG_W'(i))) state_nxt[i] = DONE;
                DONE:    if (rsp_ready[i]) state_nxt[i] = IDLE;
                default: state_nxt[i] = IDLE;
            endcase
            eligible[i]  = req_valid[i] && (state[i] == IDLE);
            rsp_valid[i] = (state[i] == DONE);
            if (state[i] != IDLE) busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_fmpu_sched.sv
// tb/tb_fmpu_sched.sv - self-checking bench for fmpu_sched with behavioural fmpu models
module tb_fmpu_sched;

    logic clk_alu;
    initial clk_alu = 1'b0;
    always #5 clk_alu = ~clk_alu;

    int tests = 0;
    int fails = 0;

    // NREQ=2, MUL_LAT=1 instance
    logic        rst_alu_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_sign;
    logic [31:0] req_a, req_b;
    logic [10:0] mul_a_mant, mul_b_mant;
    logic [4:0]  mul_a_exp, mul_b_exp;
    logic        mul_a_sign, mul_b_sign;
    logic [21:0] res_mant;
    logic [5:0]  res_exp;
    logic        res_sign;
    logic [43:0] rsp_mant;
    logic [11:0] rsp_exp;
    logic        busy;

    fmpu_sched #(.NREQ(2), .MUL_LAT(1)) dut (
        .clk_alu(clk_alu), .rst_alu_n(rst_alu_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_a_mant(mul_a_mant), .mul_b_mant(mul_b_mant),
        .mul_a_exp(mul_a_exp), .mul_b_exp(mul_b_exp),
        .mul_a_sign(mul_a_sign), .mul_b_sign(mul_b_sign),
        .mul_res_mant(res_mant), .mul_res_exp(res_exp), .mul_res_sign(res_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_mant(rsp_mant), .rsp_exp(rsp_exp), .rsp_sign(rsp_sign), .busy(busy)
    );

    // fmpu model, one register stage
    always @(posedge clk_alu) begin
        res_mant <= 22'(mul_a_mant) * 22'(mul_b_mant);
        res_exp  <= 6'(mul_a_exp) + 6'(mul_b_exp);
        res_sign <= mul_a_sign ^ mul_b_sign;
    end

    // NREQ=4, MUL_LAT=3 instance
    logic        rst4_n;
    logic [3:0]  req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_sign4;
    logic [63:0] req_a4, req_b4;
    logic [10:0] m4_a_mant, m4_b_mant;
    logic [4:0]  m4_a_exp, m4_b_exp;
    logic        m4_a_sign, m4_b_sign;
    logic [21:0] p4_mant [3];
    logic [5:0]  p4_exp  [3];
    logic        p4_sign [3];
    logic [87:0] rsp_mant4;
    logic [23:0] rsp_exp4;
    logic        busy4;

    fmpu_sched #(.NREQ(4), .MUL_LAT(3)) dut4 (
        .clk_alu(clk_alu), .rst_alu_n(rst4_n),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_a(req_a4), .req_b(req_b4),
        .mul_a_mant(m4_a_mant), .mul_b_mant(m4_b_mant),
        .mul_a_exp(m4_a_exp), .mul_b_exp(m4_b_exp),
        .mul_a_sign(m4_a_sign), .mul_b_sign(m4_b_sign),
        .mul_res_mant(p4_mant[2]), .mul_res_exp(p4_exp[2]), .mul_res_sign(p4_sign[2]),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_mant(rsp_mant4), .rsp_exp(rsp_exp4), .rsp_sign(rsp_sign4), .busy(busy4)
    );

    // fmpu model, three register stages
    always @(posedge clk_alu) begin
        p4_mant[0] <= 22'(m4_a_mant) * 22'(m4_b_mant);
        p4_exp[0]  <= 6'(m4_a_exp) + 6'(m4_b_exp);
        p4_sign[0] <= m4_a_sign ^ m4_b_sign;
        for (int s = 1; s < 3; s++) begin
            p4_mant[s] <= p4_mant[s-1];
            p4_exp[s]  <= p4_exp[s-1];
            p4_sign[s] <= p4_sign[s-1];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk_alu);
        #1;
    endtask

    task automatic do_reset();
        rst_alu_n = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk_alu);
        #1;
        rst_alu_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic [10:0] am, bm;
        logic [4:0]  ae, be;
        logic [21:0] pm;
        logic [5:0]  pe;
        logic        ps;
    } vec_t;

    vec_t vecs [5];
    logic [3:0] exp_rdy4 [10];
    logic [3:0] exp_rsp4 [10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h3C00, 16'h4000, 11'h400, 11'h400, 5'd15, 5'd16, 22'h100000, 6'd31, 1'b0};
        vecs[1] = '{16'h8001, 16'h0001, 11'h001, 11'h001, 5'd0,  5'd0,  22'h000001, 6'd0,  1'b1};
        vecs[2] = '{16'hC200, 16'h3800, 11'h600, 11'h400, 5'd16, 5'd14, 22'h180000, 6'd30, 1'b1};
        vecs[3] = '{16'h7C00, 16'hFE00, 11'h400, 11'h600, 5'd31, 5'd31, 22'h180000, 6'd62, 1'b1};
        vecs[4] = '{16'h03FF, 16'h7BFF, 11'h3FF, 11'h7FF, 5'd0,  5'd30, 22'h1FF401, 6'd30, 1'b0};
        exp_rdy4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_rsp4 = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

        rst_alu_n = 1'b0; rst4_n = 1'b0;
        req_valid = '0; rsp_ready = 2'b11; req_a = '0; req_b = '0;
        req_valid4 = '0; rsp_ready4 = '0; req_a4 = '0; req_b4 = '0;
        #1;
        check("reset req_ready", 64'(req_ready), 64'h0);
        check("reset rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset mul_a", 64'({mul_a_sign, mul_a_exp, mul_a_mant}), 64'h0);
        check("reset rsp_mant", 64'(rsp_mant), 64'h0);

        // single-op vectors on requester 0
        do_reset();
        for (int v = 0; v < 5; v++) begin
            req_valid = 2'b01; req_a = {16'h0, vecs[v].a}; req_b = {16'h0, vecs[v].b};
            #1;
            check($sformatf("v%0d c0 req_ready", v), 64'(req_ready), 64'h1);
            cyc(); req_valid = '0; #1;
            check($sformatf("v%0d mul_a", v), 64'({mul_a_sign, mul_a_exp, mul_a_mant}),
                  64'({vecs[v].a[15], vecs[v].ae, vecs[v].am}));
            check($sformatf("v%0d mul_b", v), 64'({mul_b_sign, mul_b_exp, mul_b_mant}),
                  64'({vecs[v].b[15], vecs[v].be, vecs[v].bm}));
            check($sformatf("v%0d c1 busy", v), 64'(busy), 64'h1);
            cyc(); #1;
            check($sformatf("v%0d c2 rsp_valid", v), 64'(rsp_valid), 64'h0);
            check($sformatf("v%0d c2 mul_a hold", v), 64'(mul_a_mant), 64'(vecs[v].am));
            cyc(); #1;
            check($sformatf("v%0d c3 rsp_valid", v), 64'(rsp_valid), 64'h1);
            check($sformatf("v%0d rsp_mant", v), 64'(rsp_mant[21:0]), 64'(vecs[v].pm));
            check($sformatf("v%0d rsp_exp", v), 64'(rsp_exp[5:0]), 64'(vecs[v].pe));
            check($sformatf("v%0d rsp_sign", v), 64'(rsp_sign[0]), 64'(vecs[v].ps));
            cyc(); #1;
            check($sformatf("v%0d c4 rsp_valid", v), 64'(rsp_valid), 64'h0);
            check($sformatf("v%0d c4 busy", v), 64'(busy), 64'h0);
            cyc();
        end

        // contention: both valid from reset
        do_reset();
        rsp_ready = 2'b00; req_valid = 2'b11;
        req_a = {16'h4000, 16'h3C00}; req_b = {16'h4200, 16'h3C00};
        #1; check("cont c0 req_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b10; #1; check("cont c1 req_ready", 64'(req_ready), 64'h2);
        cyc(); req_valid = 2'b00; #1; check("cont c2 rsp_valid", 64'(rsp_valid), 64'h0);
        cyc(); #1;
        check("cont c3 rsp_valid", 64'(rsp_valid), 64'h1);
        check("cont rsp0", 64'({rsp_sign[0], rsp_exp[5:0], rsp_mant[21:0]}), 64'({1'b0, 6'd30, 22'h100000}));
        cyc(); rsp_ready = 2'b11; #1;
        check("cont c4 rsp_valid", 64'(rsp_valid), 64'h3);
        check("cont rsp1", 64'({rsp_sign[1], rsp_exp[11:6], rsp_mant[43:22]}), 64'({1'b0, 6'd32, 22'h180000}));
        cyc(); req_valid = 2'b11; #1;
        check("cont c5 rsp_valid", 64'(rsp_valid), 64'h0);
        check("cont c5 regrant", 64'(req_ready), 64'h1);

        // backpressure on requester 0 while requester 1 runs
        do_reset();
        rsp_ready = 2'b10; req_valid = 2'b01;
        req_a = {16'hC000, 16'h3C00}; req_b = {16'h3C00, 16'h4000};
        #1; check("bp c0 req_ready", 64'(req_ready), 64'h1);
        cyc(); #1; check("bp c1 req_ready", 64'(req_ready), 64'h0);
        cyc();
        for (int k = 3; k <= 7; k++) begin
            cyc(); req_valid = (k == 3) ? 2'b11 : 2'b01; #1;
            check($sformatf("bp c%0d req_ready", k), 64'(req_ready), (k == 3) ? 64'h2 : 64'h0);
            check($sformatf("bp c%0d rsp_valid0", k), 64'(rsp_valid[0]), 64'h1);
            check($sformatf("bp c%0d rsp0 stable", k), 64'({rsp_sign[0], rsp_exp[5:0], rsp_mant[21:0]}),
                  64'({1'b0, 6'd31, 22'h100000}));
            check($sformatf("bp c%0d rsp_valid1", k), 64'(rsp_valid[1]), (k == 6) ? 64'h1 : 64'h0);
            if (k == 6)
                check("bp rsp1", 64'({rsp_sign[1], rsp_exp[11:6], rsp_mant[43:22]}), 64'({1'b1, 6'd31, 22'h100000}));
        end
        cyc(); rsp_ready = 2'b11; #1;
        check("bp c8 req_ready", 64'(req_ready), 64'h0);
        check("bp c8 rsp_valid", 64'(rsp_valid), 64'h1);
        cyc(); #1;
        check("bp c9 rsp_valid", 64'(rsp_valid), 64'h0);
        check("bp c9 req_ready", 64'(req_ready), 64'h1);

        // asynchronous reset one cycle after a grant
        do_reset();
        req_valid = 2'b01; req_a = {16'h0, 16'h4000}; req_b = {16'h0, 16'h4000};
        #1; check("rst c0 req_ready", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00; #1;
        check("rst c1 busy", 64'(busy), 64'h1);
        rst_alu_n = 1'b0; #1;
        check("rst async busy", 64'(busy), 64'h0);
        check("rst async mul_a", 64'(mul_a_mant), 64'h0);
        cyc(); cyc(); rst_alu_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            check($sformatf("rst post%0d rsp_valid", k), 64'(rsp_valid), 64'h0);
            check($sformatf("rst post%0d busy", k), 64'(busy), 64'h0);
        end
        req_valid = 2'b11; req_a = {16'h3C00, 16'h3C00}; req_b = {16'h3C00, 16'hC000};
        #1; check("rst fresh grant", 64'(req_ready), 64'h1);
        cyc(); req_valid = 2'b00; cyc(); cyc(); #1;
        check("rst fresh rsp_valid", 64'(rsp_valid), 64'h1);
        check("rst fresh rsp0", 64'({rsp_sign[0], rsp_exp[5:0], rsp_mant[21:0]}), 64'({1'b1, 6'd31, 22'h100000}));

        // NREQ=4, MUL_LAT=3 sweep
        rst4_n = 1'b1;
        req_valid4 = 4'b1111; rsp_ready4 = 4'b1111;
        req_a4 = {16'h4800, 16'h4400, 16'h4000, 16'h3C00};
        req_b4 = {4{16'h3C00}};
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("sw c%0d req_ready", c), 64'(req_ready4), 64'(exp_rdy4[c]));
            check($sformatf("sw c%0d rsp_valid", c), 64'(rsp_valid4), 64'(exp_rsp4[c]));
            for (int i = 0; i < 4; i++) begin
                if (c == i + 5)
                    check($sformatf("sw rsp%0d", i), 64'({rsp_exp4[i*6 +: 6], rsp_mant4[i*22 +: 22]}),
                          64'({6'(30 + i), 22'h100000}));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
